// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the frame-buffer data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Active-low request/strobe level.
  localparam logic ASSERT_L = 1'b0;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Index width for a memory of the given depth (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arb_if.sv
// Write channel plus NUM_RD read channels of the frame-buffer memory.
interface data_mem_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_RD     = 2
);
  logic                                wr_en;
  logic [ADDR_WIDTH-1:0]               wr_addr;
  logic [DATA_WIDTH-1:0]               wr_data;
  logic [DATA_WIDTH/8-1:0]             wr_be;
  logic                                wr_ack;
  logic [NUM_RD-1:0]                   rd_en;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   rd_addr;
  logic [NUM_RD-1:0]                   rd_ack;
  logic [NUM_RD-1:0]                   rd_valid;
  logic [DATA_WIDTH-1:0]               rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  wr_ack, rd_ack, rd_valid, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output wr_ack, rd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/data_mem_arb_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt_ptr
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt     = '0;
    nxt_ptr = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx] && !mask[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        nxt_ptr  = (int'(idx) == N - 1) ? '0 : idx + PW'(1);
      end
    end
  end

endmodule

// File: rtl/data_mem_arb.sv
// Frame-buffer data memory: one write and NUM_RD read channels share a single
// port through a round-robin arbiter; a clear sweep zeroes it after reset/clr.
module data_mem_arb
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int RD_LAT     = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  output logic           busy,
  data_mem_arb_if.slave  bus
);

  localparam int N     = NUM_RD + 1;
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = idx_w(MEM_DEPTH);
  localparam int LAT   = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MEM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                       state, state_nxt;
  logic [IDX_W-1:0]             sweep_cnt;
  logic [PW-1:0]                ptr, nxt_ptr;
  logic [N-1:0]                 req, mask, raw_gnt, gnt;
  logic [NUM_RD-1:0]            rd_gnt;
  logic [ADDR_WIDTH-1:0]        rd_sel;
  logic                         run, wr_go, rd_in_rng;
  logic [LAT:1][NUM_RD-1:0]     vld_pipe;
  logic [LAT:1][DATA_WIDTH-1:0] dat_pipe;

  function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH + 1)'(MEM_DEPTH);
  endfunction

  assign run  = (state == RUN);
  assign busy = (state == CLEAR);

  // Requester 0 is the write channel; a requester acked last cycle is masked
  // so a held request is only re-served after one idle cycle.
  always_comb begin
    req[0]  = (bus.wr_en == ASSERT_L);
    mask[0] = bus.wr_ack;
    for (int c = 0; c < NUM_RD; c++) begin
      req[c+1]  = (bus.rd_en[c] == ASSERT_L);
      mask[c+1] = bus.rd_ack[c];
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .mask    (mask),
    .ptr     (ptr),
    .gnt     (raw_gnt),
    .nxt_ptr (nxt_ptr)
  );

  assign gnt    = run ? raw_gnt : '0;
  assign rd_gnt = gnt[N-1:1];
  assign wr_go  = gnt[0] && in_rng(bus.wr_addr);

  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < NUM_RD; c++)
      if (rd_gnt[c]) rd_sel = bus.rd_addr[c];
  end
  assign rd_in_rng = in_rng(rd_sel);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (sweep_cnt == LAST) state_nxt = RUN;
      RUN:     if (clr == ASSERT_L)   state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sweep_cnt    <= '0;
      ptr          <= '0;
      bus.wr_ack   <= 1'b0;
      bus.rd_ack   <= '0;
      vld_pipe     <= '0;
      dat_pipe     <= '0;
    end else begin
      sweep_cnt  <= (busy && sweep_cnt != LAST) ? sweep_cnt + IDX_W'(1) : '0;
      if (run) ptr <= nxt_ptr;
      bus.wr_ack <= gnt[0];
      bus.rd_ack <= rd_gnt;
      // Data stages only load behind a valid so rd_data holds between reads.
      vld_pipe[1] <= rd_gnt;
      if (|rd_gnt) dat_pipe[1] <= rd_in_rng ? mem[rd_sel[IDX_W-1:0]] : '0;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (|vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (busy) mem[sweep_cnt] <= '0;
    else if (wr_go)
      for (int b = 0; b < BE_W; b++)
        if (bus.wr_be[b]) mem[bus.wr_addr[IDX_W-1:0]][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
  end

  assign bus.rd_valid = vld_pipe[LAT];
  assign bus.rd_data  = dat_pipe[LAT];

endmodule

// File: tb/tb_data_mem_arb.sv
// Directed and random checks of data_mem_arb against a transaction-level model.
module tb_data_mem_arb;

  localparam int DW = 32, AW = 5, DEPTH = 16, NRD = 2, LAT = 2, N = NRD + 1;

  typedef struct { bit v; int ch; logic [31:0] d; } rd_ent_t;

  logic clk, reset, clr, busy;
  data_mem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD)) bus ();

  data_mem_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .NUM_RD(NRD), .RD_LAT(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .busy  (busy),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model state.
  int          m_clear_left, m_ptr;
  bit [N-1:0]  m_prev;
  logic [31:0] m_mem [DEPTH];
  rd_ent_t     pipe_q [$];
  logic        e_wack;
  logic [1:0]  e_rack, e_valid;
  logic [31:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy",     busy,         (m_clear_left > 0) ? 32'd1 : 32'd0);
    chk("wr_ack",   bus.wr_ack,   e_wack);
    chk("rd_ack",   bus.rd_ack,   e_rack);
    chk("rd_valid", bus.rd_valid, e_valid);
    chk("rd_data",  bus.rd_data,  e_data);
  endtask

  task automatic model_reset();
    m_clear_left = DEPTH;
    m_ptr  = 0;
    m_prev = '0;
    foreach (m_mem[j]) m_mem[j] = '0;
    e_wack = 1'b0; e_rack = '0; e_valid = '0; e_data = '0;
    pipe_q = {};
    for (int k = 0; k < LAT - 1; k++) pipe_q.push_back('{v:1'b0, ch:0, d:32'h0});
  endtask

  // What the spec says one clock edge does, given the inputs now on the bus.
  task automatic model_edge();
    rd_ent_t ne, ent;
    int win, a;
    ne  = '{v:1'b0, ch:0, d:32'h0};
    win = -1;
    if (m_clear_left > 0) m_clear_left--;
    else begin
      for (int k = 0; k < N; k++) begin
        int i;
        bit rq;
        i = (m_ptr + k) % N;
        if (i == 0) rq = (bus.wr_en == 1'b0);
        else        rq = (bus.rd_en[i-1] == 1'b0);
        if (win < 0 && rq && !m_prev[i]) win = i;
      end
      if (win == 0) begin
        a = int'(bus.wr_addr);
        if (a < DEPTH)
          for (int b = 0; b < 4; b++)
            if (bus.wr_be[b]) m_mem[a][b*8 +: 8] = bus.wr_data[b*8 +: 8];
      end
      if (win > 0) begin
        a = int'(bus.rd_addr[win-1]);
        ne.v  = 1'b1;
        ne.ch = win - 1;
        ne.d  = (a < DEPTH) ? m_mem[a] : 32'h0;
      end
      if (win >= 0) m_ptr = (win + 1) % N;
      if (clr == 1'b0) begin
        m_clear_left = DEPTH;
        foreach (m_mem[j]) m_mem[j] = '0;
      end
    end
    m_prev = '0;
    if (win >= 0) m_prev[win] = 1'b1;
    e_wack = (win == 0);
    e_rack = (win > 0) ? (2'b01 << (win - 1)) : 2'b00;
    pipe_q.push_back(ne);
    ent = pipe_q.pop_front();
    if (ent.v) begin
      e_valid = 2'b01 << ent.ch;
      e_data  = ent.d;
    end else e_valid = 2'b00;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bcnt, code, acks, vals;
    int exp_ord [6];
    exp_ord = '{0, 1, 2, 0, 1, 2};

    // Reset with a write already requested: held off for the whole sweep.
    reset = 1'b0; clr = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = 5'd5; bus.wr_data = 32'h11223344; bus.wr_be = 4'hF;
    bus.rd_en = 2'b11; bus.rd_addr[0] = '0; bus.rd_addr[1] = '0;
    do_reset();
    n = 0; bcnt = 0;
    while (bus.wr_ack !== 1'b1 && n < 40) begin
      if (busy) bcnt++;
      tick();
      n++;
    end
    chk("reset_busy_cycles", bcnt, 16);
    chk("first_wr_ack_cycle", n, 17);
    bus.wr_en = 1'b1;

    // Cleared memory reads as zero.
    bus.rd_en = 2'b10; bus.rd_addr[0] = 5'd3; tick();
    chk("zero_rd_ack", bus.rd_ack, 2'b01);
    bus.rd_en = 2'b11; tick();
    chk("zero_rd_valid", bus.rd_valid, 2'b01);
    chk("zero_rd_data", bus.rd_data, 32'h0);

    // Byte-enabled overwrite, read back on channel 1.
    bus.wr_en = 1'b0; bus.wr_data = 32'hDEADBEEF; bus.wr_be = 4'b0101; tick();
    chk("be_wr_ack", bus.wr_ack, 1'b1);
    bus.wr_en = 1'b1; tick();
    bus.rd_en = 2'b01; bus.rd_addr[1] = 5'd5; tick();
    chk("be_rd_ack", bus.rd_ack, 2'b10);
    chk("be_no_early_valid", bus.rd_valid, 2'b00);
    bus.rd_en = 2'b11; tick();
    chk("be_rd_valid", bus.rd_valid, 2'b10);
    chk("be_rd_data", bus.rd_data, 32'h11AD33EF);

    // Everyone held low: strict rotation, nobody served twice in a row.
    bus.wr_en = 1'b0; bus.wr_addr = 5'd7; bus.wr_data = 32'hCAFE0007; bus.wr_be = 4'hF;
    bus.rd_en = 2'b00; bus.rd_addr[0] = 5'd1; bus.rd_addr[1] = 5'd2;
    for (int k = 0; k < 6; k++) begin
      tick();
      code = bus.wr_ack ? 0 : bus.rd_ack[0] ? 1 : bus.rd_ack[1] ? 2 : 3;
      chk("rr_order", code, exp_ord[k]);
    end
    bus.wr_en = 1'b1; bus.rd_en = 2'b11;
    repeat (3) tick();

    // Same address twice on channel 0: two full accesses.
    acks = 0; vals = 0;
    for (int k = 0; k < 2; k++) begin
      bus.rd_en = 2'b10; bus.rd_addr[0] = 5'd7; tick();
      if (bus.rd_ack[0]) acks++;
      if (bus.rd_valid[0]) vals++;
      bus.rd_en = 2'b11; tick();
      if (bus.rd_ack[0]) acks++;
      if (bus.rd_valid[0]) vals++;
      chk("rep_rd_data", bus.rd_data, 32'hCAFE0007);
    end
    chk("rep_ack_count", acks, 2);
    chk("rep_valid_count", vals, 2);

    // clr on the same edge as a read grant: the read still completes.
    bus.rd_en = 2'b01; bus.rd_addr[1] = 5'd7; clr = 1'b0; tick();
    chk("clr_rd_ack", bus.rd_ack, 2'b10);
    chk("clr_busy_rise", busy, 1'b1);
    clr = 1'b1; bus.rd_en = 2'b11;
    n = 1; tick();
    chk("clr_inflight_valid", bus.rd_valid, 2'b10);
    chk("clr_inflight_data", bus.rd_data, 32'hCAFE0007);
    while (busy && n < 40) begin n++; tick(); end
    chk("clr_busy_cycles", n, 16);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_en = 2'b10; bus.rd_addr[0] = AW'(a); tick();
      bus.rd_en = 2'b11; tick();
      chk("clr_readback_valid", bus.rd_valid, 2'b01);
      chk("clr_readback_data", bus.rd_data, 32'h0);
    end

    // Reset in the middle of a sweep restarts it from zero.
    clr = 1'b0; tick();
    clr = 1'b1;
    repeat (9) tick();
    do_reset();
    n = 0;
    while (busy && n < 40) begin n++; tick(); end
    chk("midsweep_busy_cycles", n, 16);

    // Out-of-range accesses are acked, writes dropped, reads zero.
    bus.wr_en = 1'b0; bus.wr_addr = 5'd4; bus.wr_data = 32'h0BADF00D; bus.wr_be = 4'hF; tick();
    bus.wr_en = 1'b1; tick();
    bus.wr_en = 1'b0; bus.wr_addr = 5'd20; bus.wr_data = 32'hFFFFFFFF; tick();
    chk("oor_wr_ack", bus.wr_ack, 1'b1);
    bus.wr_en = 1'b1; tick();
    bus.rd_en = 2'b10; bus.rd_addr[0] = 5'd4; tick();
    bus.rd_en = 2'b11; tick();
    chk("oor_alias_data", bus.rd_data, 32'h0BADF00D);
    bus.rd_en = 2'b01; bus.rd_addr[1] = 5'd20; tick();
    chk("oor_rd_ack", bus.rd_ack, 2'b10);
    bus.rd_en = 2'b11; tick();
    chk("oor_rd_valid", bus.rd_valid, 2'b10);
    chk("oor_rd_data", bus.rd_data, 32'h0);

    // Random traffic, occasional clr.
    for (int k = 0; k < 400; k++) begin
      bus.wr_en      = 1'($urandom_range(0, 1));
      bus.wr_addr    = AW'($urandom_range(0, 19));
      bus.wr_data    = $urandom;
      bus.wr_be      = 4'($urandom_range(0, 15));
      bus.rd_en      = 2'($urandom_range(0, 3));
      bus.rd_addr[0] = AW'($urandom_range(0, 19));
      bus.rd_addr[1] = AW'($urandom_range(0, 19));
      clr            = ($urandom_range(0, 63) != 0);
      tick();
    end
    clr = 1'b1; bus.wr_en = 1'b1; bus.rd_en = 2'b11;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arb.md
# data_mem_arb

Parametrised single-clock frame-buffer data memory shared by one write channel and NUM_RD read channels. It replaces single-requester access with a round-robin arbiter, per-channel request/acknowledge handshakes, byte-enabled writes, configurable read latency and a hardware clear sweep. It sits between the frame-buffer write path (pixel input) and its readers (display scan-out, DMA).

## Interface
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- ADDR_WIDTH, 10: address width.
- MEM_DEPTH, 1 << ADDR_WIDTH: number of words; must be no greater than 2^ADDR_WIDTH.
- NUM_RD, 2: read channel count, 1 to 8.
- RD_LAT, 1: read latency in cycles; legal values are 1 and 2.
- clk  in  1  sole clock; all logic acts on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  active-low; starts a clear sweep.
- busy  out  1  high while a clear sweep runs.
- wr_en  in  1  active-low write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  active-high byte-lane enables.
- wr_ack  out  1  one-cycle pulse; the write has been committed.
- rd_en  in  NUM_RD  active-low per-channel read request.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed; channel c uses [c*ADDR_WIDTH +: ADDR_WIDTH].
- rd_ack  out  NUM_RD  one-cycle pulse per channel; the request was accepted.
- rd_valid  out  NUM_RD  one-hot; identifies the owner of rd_data.
- rd_data  out  DATA_WIDTH  shared read-data bus.

## Operation
- FSM has two states: CLEAR and RUN.
- Reset asserted: state goes to CLEAR, sweep counter to 0, round-robin pointer to 0. All outputs go to 0 except busy, which goes to 1.
- CLEAR:
  - One word is zeroed per cycle at the sweep counter address.
  - After address MEM_DEPTH-1 is zeroed, the FSM moves to RUN and busy falls.
  - No acks are issued. Requests are held off, not dropped; requesters keep their request asserted.
- RUN:
  - Requesters are indexed 0 = write, 1..NUM_RD = read channels 0..NUM_RD-1.
  - A requester is eligible when its enable is low and it was not acked in the previous cycle.
  - Round-robin grant: starting from pointer, the first eligible requester wins. The pointer then moves to winner+1, modulo NUM_RD+1.
  - Exactly one memory operation occurs per cycle.
- Write grant: only lanes with wr_be set are updated. If wr_be is all zero, the write is still acked and memory is unchanged.
- Read grant: data is mem[rd_addr] as of the grant edge. A write granted on an earlier edge is visible.
- Out-of-range address (address >= MEM_DEPTH): a write is acked and discarded; a read is acked and returns 0.
- clr low while in RUN: the FSM enters CLEAR at the next edge with counter 0. Reads already in flight (RD_LAT=2) still deliver their rd_valid.
- clr low while in CLEAR: ignored.
- reset asserted mid-sweep: the sweep restarts from address 0.
- Unlike the previous memory, a repeated address is not suppressed. Every handshake performs an access.

## Timing
- Request sampled low at edge E: the grant happens at E, and the ack is high during cycle E+1.
- The acked requester is masked at E+1. It must deassert by E+2 or the request counts as a new one. Peak per-channel rate is one operation every 2 cycles.
- Aggregate throughput: one operation per cycle when two or more requesters alternate.
- Read latency:
  - RD_LAT=1: rd_valid and rd_data are valid during cycle E+1, coincident with rd_ack.
  - RD_LAT=2: they are valid during cycle E+2.
- rd_data holds its last value when no rd_valid bit is set.
- Clear duration: MEM_DEPTH cycles from reset release or clr sample. busy is high for exactly those cycles.
- Worst-case grant wait: NUM_RD+1 cycles after RUN is entered.

## Structure
- Shared include frame_buf_defs.vh: ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H macros, the CLEAR/RUN state encodings, and the legal RD_LAT values.
- Sub-module rr_arbiter, parameter N: request vector, mask vector, and pointer in; one-hot grant and next pointer out. It is purely combinational; the pointer register lives in data_mem_arb.
- Memory array, sweep counter, and read pipeline stay in the top-level module.

## Test plan
- Reset release with MEM_DEPTH=16: busy=1 for 16 cycles, with no acks while wr_en is held low. The first wr_ack occurs one cycle after busy falls; a later read of any address returns 0.
- Write 0xDEADBEEF to addr 5 with wr_be=4'b0101, over prior 0x11223344: channel 1 reads 0x11AD33EF, with rd_valid=2'b10 one cycle after rd_ack at RD_LAT=1, or two cycles at RD_LAT=2.
- Write and both read channels all held low continuously: ack order is write, rd0, rd1, write, …. No channel is acked on two consecutive cycles.
- clr pulsed while in RUN with an RD_LAT=2 read granted on the same edge: that read's rd_valid still appears, then busy=1 for MEM_DEPTH cycles and all words read back 0.
- Same address 7 read twice by channel 0 using two handshakes: two rd_acks and two rd_valids, both returning identical data.
- reset asserted at sweep address 9 then released: busy stays high a full MEM_DEPTH cycles. Out-of-range read (addr 20, MEM_DEPTH=16) is acked and returns 0.
